vga_sync_controller: RTL
========================

# vga_sync_controller

Sequences VGA horizontal and vertical timing for the display path. A clock divider generates a pixel tick, and the block runs horizontal and vertical counters from it. It decodes those counters into HSync, VSync, a video-active window and pixel coordinates for the pixel generator. A run/stop state machine ensures a stop request never truncates a frame, so the monitor always sees whole frames.

## Interface
- CLK_DIV, 2: system clocks per pixel tick (50 MHz clk → 25 MHz pixels); must be ≥1.
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal regions in pixels; H_TOTAL = sum = 800.
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical regions in lines; V_TOTAL = sum = 525.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- Enable  input  1  level request to run; sampled every clk.
- HSync  output  1  horizontal sync, active-low.
- VSync  output  1  vertical sync, active-low.
- VideoOn  output  1  high while the counters are inside the visible window.
- PixelX  output  10  horizontal pixel counter, 0..H_TOTAL-1.
- PixelY  output  10  vertical line counter, 0..V_TOTAL-1.
- PixelTick  output  1  one-clk strobe on the clk where counters advance.
- FrameStart  output  1  one-clk strobe when counters wrap to (0,0) while running.
- Busy  output  1  high in RUN or STOPPING.

## Operation
- Regions are ordered visible, front porch, sync, back porch, on both axes.
- HSync = 0 iff H_VISIBLE+H_FRONT ≤ PixelX < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- VSync = 0 iff 490 ≤ PixelY ≤ 491.
- VideoOn = (PixelX < H_VISIBLE) && (PixelY < V_VISIBLE).
- Divider: counts 0..CLK_DIV-1 and wraps; PixelTick = 1 when divider == CLK_DIV-1 and state ≠ IDLE.
- On PixelTick:
  - PixelX increments; at H_TOTAL-1 it wraps to 0 and PixelY increments.
  - PixelY wraps to 0 after V_TOTAL-1.
  - Both counters wrap modulo their totals, never exceeding them.
- States:
  - IDLE: counters and divider held at 0; HSync = VSync = 1; VideoOn = 0; Busy = 0.
    - Enable = 1 → RUN on the next edge.
  - RUN: counting.
    - Enable = 0 → STOPPING on the next edge; counting continues.
  - STOPPING: counting.
    - On the PixelTick that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0) → IDLE; FrameStart is not pulsed on that tick.
    - Enable = 1 before that tick → RUN with no counter disturbance.
- Simultaneous events:
  - STOPPING with Enable returning to 1 on the wrap tick: RUN wins; FrameStart pulses.
  - IDLE with Enable = 1 and reset = 1: reset wins.
- FrameStart pulses on each wrap to (0,0) in RUN. It also pulses on the first clk of RUN after IDLE, when counters are at (0,0).
- Reset: synchronous, may occur mid-frame. It immediately forces IDLE, counters 0, divider 0, HSync = VSync = 1, VideoOn = 0, PixelTick = FrameStart = Busy = 0. No partial-frame completion.

## Timing
- All outputs are registered.
  - HSync, VSync and VideoOn update on the same edge as PixelX/PixelY and always reflect the current counter values: zero relative skew.
  - PixelTick and FrameStart are asserted in the clk cycle before the edge on which the counters change.
- IDLE → RUN: Busy rises one clk after Enable is sampled high.
  - First counter advance occurs CLK_DIV clks after entering RUN.
- Line period: H_TOTAL·CLK_DIV = 1600 clks.
  - HSync low 192 clks, starting 1312 clks after PixelX = 0.
- Frame period: 800·525·2 = 840000 clks.
  - VSync low 2 lines = 3200 clks, starting 490·1600 = 784000 clks after frame start.
- CLK_DIV = 1: PixelTick is constantly high in RUN/STOPPING.

## Test plan
- Reset check: hold reset 3 clks while Enable = 1 → HSync = VSync = 1, VideoOn = 0, PixelX = PixelY = 0, Busy = 0, no strobes.
- Line timing: Enable = 1, measure one line.
  - HSync low exactly 192 clks.
  - Falling edges 1600 clks apart.
  - VideoOn high 1280 clks per visible line.
- Frame timing: run 2 frames.
  - VSync low 3200 clks per frame.
  - FrameStart pulses 840000 clks apart.
  - PixelY reaches 524, never 525.
- Graceful stop: drop Enable at PixelY = 100.
  - Busy stays 1 until the wrap from (799,524).
  - Then IDLE, with no FrameStart on that wrap.
- Stop abort: drop Enable at PixelY = 100, reassert at PixelY = 300.
  - Counters continue uninterrupted.
  - FrameStart pulses at the next wrap; Busy never falls.
- Mid-frame reset: assert reset at PixelX = 400, PixelY = 200.
  - Next edge: all outputs at reset values.
  - With Enable still 1 after reset release, RUN resumes with FrameStart at (0,0).

Source files
------------

// File: rtl/vga_sync_controller.sv
// VGA timing generator: pixel-tick divider, H/V counters, sync/video decode and a
// run/stop FSM that only stops at a frame boundary so the monitor never sees a partial frame.
module vga_sync_controller #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enable,
    output logic       HSync,
    output logic       VSync,
    output logic       VideoOn,
    output logic [9:0] PixelX,
    output logic [9:0] PixelY,
    output logic       PixelTick,
    output logic       FrameStart,
    output logic       Busy
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
    logic             tick_q, tick_d, fs_q, fs_d, busy_q, busy_d;
    logic             wrap;

    always_comb begin
        // tick_q marks the cycle before the advancing edge, so it gates the counters directly
        wrap = tick_q && (x_q == H_LAST) && (y_q == V_LAST);

        state_d = state_q;
        case (state_q)
            IDLE:     if (Enable) state_d = RUN;
            RUN:      if (!Enable) state_d = STOPPING;
            STOPPING: begin
                if (Enable)    state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase

        x_d = x_q;
        y_d = y_q;
        if (tick_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        if (state_q == IDLE) begin
            x_d = '0;
            y_d = '0;
        end

        if (state_q == IDLE)        div_d = '0;
        else if (div_q == DIV_LAST) div_d = '0;
        else                        div_d = div_q + 1'b1;

        tick_d = (state_d != IDLE) && (div_d == DIV_LAST);
        // a wrap that ends a stop is not a new frame; a fresh start from IDLE is
        fs_d   = (state_q == IDLE) ? (state_d == RUN) : (wrap && (state_d != IDLE));
        busy_d = (state_d != IDLE);

        // decoded from the next counter values so syncs carry zero skew against PixelX/Y
        hsync_d = (state_d == IDLE) || !((x_d >= HS_START) && (x_d < HS_END));
        vsync_d = (state_d == IDLE) || !((y_d >= VS_START) && (y_d < VS_END));
        video_d = (state_d != IDLE) && (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            tick_q  <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            tick_q  <= tick_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign VideoOn    = video_q;
    assign PixelX     = x_q;
    assign PixelY     = y_q;
    assign PixelTick  = tick_q;
    assign FrameStart = fs_q;
    assign Busy       = busy_q;

endmodule
